// File: rtl/imm_gen_fifo.sv
// Registered RISC-V immediate generator with a DEPTH-entry result FIFO and flush.
// Optional accepted-instruction counter enabled by defining IMMGEN_PERF_EN.
module imm_gen_fifo #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instr,
  input  logic [2:0]        ImmSrc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   ImmExt,
  output logic              out_illegal,
  output logic [PERF_W-1:0] perf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  logic [XLEN-1:0] r_memImm [DEPTH];
  logic            r_memIll [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [AW:0]     r_count;

  logic [XLEN-1:0] w_immExt;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;
  logic            w_unused;

  assign w_unused = ^Instr[6:0];

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Upper bits default to the sign so only the low 32 bits differ per format.
  always_comb begin
    w_immExt  = {XLEN{Instr[31]}};
    w_illegal = 1'b0;
    case (ImmSrc)
      FMT_I:   w_immExt[31:0] = {{20{Instr[31]}}, Instr[31:20]};
      FMT_S:   w_immExt[31:0] = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      FMT_B:   w_immExt[31:0] = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                                 Instr[11:8], 1'b0};
      FMT_J:   w_immExt[31:0] = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                                 Instr[30:21], 1'b0};
      FMT_U:   w_immExt[31:0] = {Instr[31:12], 12'b0};
      default: begin
        w_immExt  = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) begin
      r_memImm[r_wrPtr] <= w_immExt;
      r_memIll[r_wrPtr] <= w_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Gating on out_valid keeps the head outputs at zero when the FIFO is empty.
  assign ImmExt      = out_valid ? r_memImm[r_rdPtr] : '0;
  assign out_illegal = out_valid ? r_memIll[r_rdPtr] : 1'b0;

`ifdef IMMGEN_PERF_EN
  logic [PERF_W-1:0] r_perfCount;

  // Saturating count of handshakes; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perfCount <= '0;
    end else if (w_push && (r_perfCount != {PERF_W{1'b1}})) begin
      r_perfCount <= r_perfCount + 1'b1;
    end
  end

  assign perf_count = r_perfCount;
`else
  assign perf_count = '0;
`endif

endmodule

// File: tb/tb_imm_gen_fifo.sv
// Directed self-checking bench for imm_gen_fifo: a 32-bit and a 64-bit instance share stimulus.
module tb_imm_gen_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] Instr;
  logic [2:0]  ImmSrc;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] ImmExt;
  logic        out_illegal;
  logic [3:0]  perf_count;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] ImmExt64;
  logic        out_illegal64;
  logic [3:0]  perf_count64;

  int checks = 0;
  int errors = 0;

`ifdef IMMGEN_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  imm_gen_fifo #(.XLEN(32), .DEPTH(4), .PERF_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .Instr(Instr), .ImmSrc(ImmSrc),
    .out_valid(out_valid), .out_ready(out_ready), .ImmExt(ImmExt),
    .out_illegal(out_illegal), .perf_count(perf_count)
  );

  imm_gen_fifo #(.XLEN(64), .DEPTH(4), .PERF_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .Instr(Instr), .ImmSrc(ImmSrc),
    .out_valid(out_valid64), .out_ready(out_ready), .ImmExt(ImmExt64),
    .out_illegal(out_illegal64), .perf_count(perf_count64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [2:0] src);
    in_valid = 1'b1;
    Instr    = instr;
    ImmSrc   = src;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [3:0] perfExp(input int n);
    if (PERF_ON == 0) return 4'd0;
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  logic [31:0] fillImm [4];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; Instr = '0; ImmSrc = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_immext", 64'(ImmExt), 64'd0);
    checkOutput("rst_illegal", 64'(out_illegal), 64'd0);
    checkOutput("rst_perf", 64'(perf_count), 64'd0);

    // I-type addi x1,x0,-1 appears one cycle after the push
    applyStimulus(32'hFFF00093, 3'b000);
    checkOutput("i_valid", 64'(out_valid), 64'd1);
    checkOutput("i_imm", 64'(ImmExt), 64'h0000_0000_FFFF_FFFF);
    checkOutput("i_imm64", ImmExt64, 64'hFFFF_FFFF_FFFF_FFFF);
    popOne();
    checkOutput("i_empty", 64'(out_valid), 64'd0);

    // U-type and S-type, checked at both widths
    applyStimulus(32'h800002B7, 3'b100);
    checkOutput("u_imm32", 64'(ImmExt), 64'h0000_0000_8000_0000);
    checkOutput("u_imm64", ImmExt64, 64'hFFFF_FFFF_8000_0000);
    popOne();
    applyStimulus(32'hFE112E23, 3'b001);
    checkOutput("s_imm32", 64'(ImmExt), 64'h0000_0000_FFFF_FFFC);
    checkOutput("s_imm64", ImmExt64, 64'hFFFF_FFFF_FFFF_FFFC);
    popOne();

    // B: imm = 1,1,111111,1000,0 = -16; J: -4; ImmSrc 111 illegal
    applyStimulus(32'hFE0008E3, 3'b010);
    applyStimulus(32'hFFDFF06F, 3'b011);
    applyStimulus(32'hFFDFF06F, 3'b111);
    checkOutput("b_imm", 64'(ImmExt), 64'h0000_0000_FFFF_FFF0);
    checkOutput("b_legal", 64'(out_illegal), 64'd0);
    popOne();
    checkOutput("j_imm", 64'(ImmExt), 64'h0000_0000_FFFF_FFFC);
    checkOutput("j_imm64", ImmExt64, 64'hFFFF_FFFF_FFFF_FFFC);
    popOne();
    checkOutput("ill_imm", 64'(ImmExt), 64'd0);
    checkOutput("ill_flag", 64'(out_illegal), 64'd1);
    checkOutput("ill_imm64", ImmExt64, 64'd0);
    popOne();
    checkOutput("ill_empty", 64'(out_valid), 64'd0);

    // Fill to DEPTH with a stalled consumer; pointers wrap during this
    fillImm[0] = 32'h0000_0001; fillImm[1] = 32'h0000_0002;
    fillImm[2] = 32'h0000_07FF; fillImm[3] = 32'hFFFF_F800;
    applyStimulus(32'h00100093, 3'b000);
    applyStimulus(32'h00200093, 3'b000);
    applyStimulus(32'h7FF00093, 3'b000);
    checkOutput("fill3_ready", 64'(in_ready), 64'd1);
    applyStimulus(32'h80000093, 3'b000);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; Instr = 32'h00500093; ImmSrc = 3'b000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("stall_head%0d", i), 64'(ImmExt), 64'(fillImm[0]));
      checkOutput($sformatf("stall_ready%0d", i), 64'(in_ready), 64'd0);
    end
    // Pop while full with in_valid held: no push may sneak in this edge
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("popfull_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("drain%0d", i), 64'(ImmExt), 64'(fillImm[i]));
      popOne();
    end
    checkOutput("drain_empty", 64'(out_valid), 64'd0);

    // Flush with three entries and a concurrent push
    applyStimulus(32'h00300093, 3'b000);
    applyStimulus(32'h00400093, 3'b000);
    applyStimulus(32'h00500093, 3'b000);
    flush = 1'b1; in_valid = 1'b1; Instr = 32'h00900093; ImmSrc = 3'b000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("flush_lost", 64'(out_valid), 64'd0);
    applyStimulus(32'h00A00093, 3'b000);
    checkOutput("post_flush_imm", 64'(ImmExt), 64'd10);
    popOne();

    // Reset mid-stream empties the FIFO
    applyStimulus(32'h00B00093, 3'b000);
    applyStimulus(32'h00C00093, 3'b000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_perf", 64'(perf_count), 64'd0);

    // 20 streaming pushes with a flush after the tenth; counter saturates at 15
    out_ready = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(32'h00100093, 3'b000);
      if (n == 10) begin
        checkOutput("perf10", 64'(perf_count), 64'(perfExp(10)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("perf_flush", 64'(perf_count), 64'(perfExp(10)));
      end
    end
    out_ready = 1'b0;
    checkOutput("perf20", 64'(perf_count), 64'(perfExp(20)));
    checkOutput("perf20_64", 64'(perf_count64), 64'(perfExp(20)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
